// File: rtl/matrix_stream_bridge_pkg.sv
// Shared constants and the state enumeration for the matrix stream bridge.
package matrix_stream_bridge_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int NUM_ELEM = DIM * DIM;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        WAIT   = 2'd2,
        SEND   = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_stream_bridge.sv
// Byte-stream front end for a matrix multiplier: loads A then B row-major, waits for a
// clean multiplier pass, captures C and streams it back out row-major.
module matrix_stream_bridge #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [ELEM_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ELEM_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIM*DIM*ELEM_W-1:0]     matriz_a,
    output logic [DIM*DIM*ELEM_W-1:0]     matriz_b,
    input  logic [DIM*DIM*ELEM_W-1:0]     matriz_c,
    input  logic                          done,
    output logic                          busy
);
    import matrix_stream_bridge_pkg::*;

    localparam int N_ELEM = DIM * DIM;
    localparam int IDX_W  = $clog2(N_ELEM);

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic [1:0]                  dcnt;
    logic [DIM*DIM*ELEM_W-1:0]   result;
    logic                        last_slot;
    logic                        in_xfer;
    logic                        out_xfer;

    assign last_slot = (idx == IDX_W'(N_ELEM - 1));
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Read side is a plain mux on the registered index, so it holds while stalled.
    assign out_data  = result[idx*ELEM_W +: ELEM_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD_A;
            idx       <= '0;
            dcnt      <= '0;
            matriz_a  <= '0;
            matriz_b  <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_xfer) begin
                        matriz_a[idx*ELEM_W +: ELEM_W] <= in_data;
                        if (last_slot) begin
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= LOAD_B;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        matriz_b[idx*ELEM_W +: ELEM_W] <= in_data;
                        if (last_slot) begin
                            idx      <= '0;
                            dcnt     <= '0;
                            in_ready <= 1'b0;
                            state    <= WAIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // The pass in flight when B completed may have mixed old and new
                    // operands, so only the second done is trusted.
                    if (done) begin
                        if (dcnt == 2'd1) begin
                            result    <= matriz_c;
                            dcnt      <= '0;
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (last_slot) begin
                            idx       <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= LOAD_A;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_stream_bridge.md
MATRIX_STREAM_BRIDGE -- requirements
Module: matrix_stream_bridge

Interface
REQ-001 SHALL have parameter DIM, default 5, matrix dimension (rows = cols).
REQ-002 SHALL have parameter ELEM_W, default 8, signed element width in bits.
REQ-003 SHALL have port clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  in  8  operand byte stream (A then B).
REQ-006 SHALL have port in_valid  in  1  in_data qualifier.
REQ-007 SHALL have port in_ready  out  1  bridge accepts in_data.
REQ-008 SHALL have port out_data  out  8  result byte stream (C).
REQ-009 SHALL have port out_valid  out  1  out_data qualifier.
REQ-010 SHALL have port out_ready  in  1  downstream accepts out_data.
REQ-011 SHALL have port matriz_a  out  200  packed operand A for the multiplier.
REQ-012 SHALL have port matriz_b  out  200  packed operand B for the multiplier.
REQ-013 SHALL have port matriz_c  in  200  packed result from the multiplier.
REQ-014 SHALL have port done  in  1  multiplier pass-complete pulse (high for the cycle in which row 4 is written).
REQ-015 SHALL have port busy  out  1  high in every state except LOAD_A.

Function
REQ-016 SHALL pack element (r,c) at bits [(r*5+c)*8 +: 8] of matriz_a, matriz_b and matriz_c.
REQ-017 SHALL use states LOAD_A, LOAD_B, WAIT, SEND, with a 5-bit index idx counting 0..24.
REQ-018 LOAD_A: in_ready=1; each transfer (in_valid && in_ready) writes in_data to matriz_a slot idx; after slot 24: idx<=0, go to LOAD_B.
REQ-019 LOAD_B: same as LOAD_A but writes matriz_b; after slot 24: idx<=0, dcnt<=0, go to WAIT.
REQ-020 First stream byte SHALL be element (0,0), row-major order, last is (4,4).
REQ-021 in_ready SHALL be 0 in WAIT and SEND; in_valid is then ignored.
REQ-022 WAIT SHALL count done pulses in a 2-bit counter dcnt; the first pulse is discarded because that pass may mix stale operands.
REQ-023 On the second done sample, WAIT SHALL capture matriz_c into an internal 200-bit result register in the same cycle, then go to SEND.
REQ-024 SEND: out_valid=1 and out_data = result slot idx (combinational from the registered idx).
REQ-025 SEND: on each out_valid && out_ready transfer, idx increments; after slot 24: idx<=0, go to LOAD_A.
REQ-026 While out_ready is low, out_data and out_valid SHALL hold stable.
REQ-027 matriz_a and matriz_b SHALL hold their values in all states; they change only via load transfers.
REQ-028 The result register SHALL be unaffected by matriz_c changes outside the capture cycle.
REQ-029 Throughput SHALL be one byte per clock on both streams when the partner is always ready/valid.
REQ-030 done pulses in LOAD_A, LOAD_B and SEND SHALL be ignored.

Reset
REQ-031 reset_n low SHALL asynchronously force the following: state=LOAD_A, idx=0, dcnt=0, matriz_a=0, matriz_b=0, result=0, out_valid=0, in_ready=1, busy=0.
REQ-032 Reset mid-load or mid-send SHALL discard the partial transfer; the next byte after release is element (0,0) of A.

Structure
REQ-033 A shared package SHALL hold DIM, ELEM_W, MAT_W (=200), NUM_ELEM (=25) and the state enumeration.
REQ-034 No sub-module SHALL be used; counter, FSM and pack/unpack logic SHALL be in one module.

Verification
REQ-035 A = 1..25 row-major, B = identity, multiplier model attached, stream back-to-back -> out bytes 1..25 in order.
REQ-036 A = all 2, B = all 3 -> every C byte = 30 (0x1E).
REQ-037 A = all -1 (0xFF), B = all 127 -> every C byte = low byte of -635 = 0x85 (8-bit wrap).
REQ-038 out_ready toggling 1,0,0,1 during SEND -> no byte lost or repeated, out_data stable while stalled, exactly 25 transfers.
REQ-039 reset_n pulsed low after 10 bytes of B -> in_ready=1, busy=0, matriz_a=0; a fresh 50-byte load computes correctly.
REQ-040 done forced high in LOAD_A, then one pulse in WAIT -> no SEND entry until the second WAIT pulse.
